// File: rtl/codifica_hamming_serial_if.sv
// Bus between the word source and the Hamming(15,11) serial transmitter.
// Adds erro_pos when HAMMING_INJECAO_ERRO_EN is defined.
interface codifica_hamming_serial_if;
    // Handshake: a word transfers on a rising edge where entrada_valida && pronto;
    // the source holds entrada stable until then, and pronto never depends on entrada_valida.
    logic [10:0] entrada;
    logic        entrada_valida;
    logic        pronto;
    logic [14:0] palavra;
    logic        saida_serial;
    logic        saida_valida;
    logic        saida_inicio;
    logic        ocupado;
    logic        estado_dbg;
`ifdef HAMMING_INJECAO_ERRO_EN
    logic [3:0]  erro_pos;
`endif

    modport master (
`ifdef HAMMING_INJECAO_ERRO_EN
        output erro_pos,
`endif
        output entrada, entrada_valida,
        input  pronto, palavra, saida_serial, saida_valida, saida_inicio, ocupado, estado_dbg
    );

    modport slave (
`ifdef HAMMING_INJECAO_ERRO_EN
        input  erro_pos,
`endif
        input  entrada, entrada_valida,
        output pronto, palavra, saida_serial, saida_valida, saida_inicio, ocupado, estado_dbg
    );
endinterface

// File: rtl/codifica_hamming_serial.sv
// Hamming(15,11) encoder that shifts the codeword out one bit per clock with a frame-start flag.
// Optional macro HAMMING_INJECAO_ERRO_EN adds erro_pos to flip one codeword bit at handshake.
module codifica_hamming_serial #(
    parameter int LSB_PRIMEIRO = 1
) (
    input logic                        clk,
    input logic                        rst,
    codifica_hamming_serial_if.slave   bus
);
    typedef enum logic {OCIOSO = 1'b0, ENVIANDO = 1'b1} estado_t;

    estado_t     estado_q;
    logic [3:0]  cont_q;
    logic [3:0]  cont_d;
    logic [14:0] palavra_q;
    logic [14:0] palavra_d;
    logic        serial_q;
    logic        valida_q;
    logic        inicio_q;
    logic        aceita;
    logic [10:0] d;

    assign d = bus.entrada;

    // Codeword index i carries Hamming position i+1; parity at indices 0, 1, 3, 7.
    always_comb begin
        palavra_d     = '0;
        palavra_d[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        palavra_d[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        palavra_d[2]  = d[0];
        palavra_d[3]  = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        palavra_d[4]  = d[1];
        palavra_d[5]  = d[2];
        palavra_d[6]  = d[3];
        palavra_d[7]  = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        palavra_d[14:8] = d[10:4];
`ifdef HAMMING_INJECAO_ERRO_EN
        for (int i = 0; i < 15; i++) begin
            if (bus.erro_pos == 4'(i + 1)) palavra_d[i] = ~palavra_d[i];
        end
`endif
    end

    function automatic logic bit_serial(input logic [14:0] p, input logic [3:0] c);
        if (LSB_PRIMEIRO != 0) return p[c];
        else                   return p[4'd14 - c];
    endfunction

    assign cont_d = cont_q + 4'd1;
    assign bus.pronto = (estado_q == OCIOSO) || (estado_q == ENVIANDO && cont_q == 4'd14);
    assign aceita     = bus.entrada_valida && bus.pronto;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            palavra_q <= '0;
            serial_q  <= 1'b0;
            valida_q  <= 1'b0;
            inicio_q  <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (aceita) begin
                        estado_q  <= ENVIANDO;
                        cont_q    <= '0;
                        palavra_q <= palavra_d;
                        serial_q  <= bit_serial(palavra_d, 4'd0);
                        valida_q  <= 1'b1;
                        inicio_q  <= 1'b1;
                    end
                end
                ENVIANDO: begin
                    if (aceita) begin
                        // Back-to-back frame: the first bit of the new word follows the last bit directly.
                        cont_q    <= '0;
                        palavra_q <= palavra_d;
                        serial_q  <= bit_serial(palavra_d, 4'd0);
                        valida_q  <= 1'b1;
                        inicio_q  <= 1'b1;
                    end else if (cont_q >= 4'd14) begin
                        estado_q  <= OCIOSO;
                        cont_q    <= '0;
                        serial_q  <= 1'b0;
                        valida_q  <= 1'b0;
                        inicio_q  <= 1'b0;
                    end else begin
                        cont_q    <= cont_d;
                        serial_q  <= bit_serial(palavra_q, cont_d);
                        inicio_q  <= 1'b0;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                    cont_q   <= '0;
                    serial_q <= 1'b0;
                    valida_q <= 1'b0;
                    inicio_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.palavra      = palavra_q;
    assign bus.saida_serial = serial_q;
    assign bus.saida_valida = valida_q;
    assign bus.saida_inicio = inicio_q;
    assign bus.ocupado      = (estado_q == ENVIANDO);
    assign bus.estado_dbg   = estado_q;
endmodule

// File: tb/tb_codifica_hamming_serial.sv
// Directed bench: one LSB-first and one MSB-first transmitter fed identical words,
// codewords and serial streams compared against hand-computed constants.
module tb_codifica_hamming_serial;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  codifica_hamming_serial_if bus_l ();
  codifica_hamming_serial_if bus_m ();

  codifica_hamming_serial #(.LSB_PRIMEIRO(1)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l.slave));
  codifica_hamming_serial #(.LSB_PRIMEIRO(0)) u_msb (.clk(clk), .rst(rst), .bus(bus_m.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic offer(input logic [10:0] dw, input logic [3:0] ep);
    bus_l.entrada = dw;
    bus_m.entrada = dw;
    bus_l.entrada_valida = 1'b1;
    bus_m.entrada_valida = 1'b1;
`ifdef HAMMING_INJECAO_ERRO_EN
    bus_l.erro_pos = ep;
    bus_m.erro_pos = ep;
`else
    if (ep != 4'd0) $display("note: erro_pos ignored in this build");
`endif
  endtask

  task automatic drop_valid();
    bus_l.entrada_valida = 1'b0;
    bus_m.entrada_valida = 1'b0;
  endtask

  // Checks one frame; entered at the negedge before the edge that accepts the offered word.
  task automatic frame(input string tag, input logic [14:0] cw, input bit chain, input logic [10:0] nd);
    @(negedge clk);
    drop_valid();
    chk({tag, "_palavra_l"}, 32'(bus_l.palavra), 32'(cw));
    chk({tag, "_palavra_m"}, 32'(bus_m.palavra), 32'(cw));
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("%s_ser_l%0d", tag, k), 32'(bus_l.saida_serial), 32'(cw[k]));
      chk($sformatf("%s_ser_m%0d", tag, k), 32'(bus_m.saida_serial), 32'(cw[14-k]));
      chk($sformatf("%s_val%0d", tag, k), {30'd0, bus_l.saida_valida, bus_m.saida_valida}, 32'h3);
      chk($sformatf("%s_ocu%0d", tag, k), {30'd0, bus_l.ocupado, bus_l.estado_dbg}, 32'h3);
      chk($sformatf("%s_ini%0d", tag, k), {30'd0, bus_l.saida_inicio, bus_m.saida_inicio},
          (k == 0) ? 32'h3 : 32'h0);
      chk($sformatf("%s_pro%0d", tag, k), {30'd0, bus_l.pronto, bus_m.pronto},
          (k == 14) ? 32'h3 : 32'h0);
      if (k == 14 && chain) offer(nd, 4'd0);
      if (k < 14) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag, input logic [14:0] pal);
    chk({tag, "_val"}, {30'd0, bus_l.saida_valida, bus_m.saida_valida}, 32'h0);
    chk({tag, "_ocu"}, {30'd0, bus_l.ocupado, bus_l.estado_dbg}, 32'h0);
    chk({tag, "_ini"}, {30'd0, bus_l.saida_inicio, bus_m.saida_inicio}, 32'h0);
    chk({tag, "_ser"}, {30'd0, bus_l.saida_serial, bus_m.saida_serial}, 32'h0);
    chk({tag, "_pro"}, {30'd0, bus_l.pronto, bus_m.pronto}, 32'h3);
    chk({tag, "_pal"}, 32'(bus_l.palavra), 32'(pal));
  endtask

  initial begin
    rst = 1'b1;
    bus_l.entrada = '0;
    bus_m.entrada = '0;
    drop_valid();
`ifdef HAMMING_INJECAO_ERRO_EN
    bus_l.erro_pos = '0;
    bus_m.erro_pos = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset", 15'h0000);

    offer(11'h000, 4'd0);
    frame("zero", 15'h0000, 1'b0, 11'h000);
    @(negedge clk);
    check_idle("zero_end", 15'h0000);

    offer(11'h7FF, 4'd0);
    frame("ones", 15'h7FFF, 1'b0, 11'h000);
    @(negedge clk);
    check_idle("ones_end", 15'h7FFF);

    offer(11'h001, 4'd0);
    frame("d0", 15'h0007, 1'b0, 11'h000);
    @(negedge clk);
    check_idle("d0_end", 15'h0007);

    // 11'h400 frame with 11'h001 offered on its last bit: no gap, new start 15 cycles later
    offer(11'h400, 4'd0);
    frame("d10", 15'h408B, 1'b1, 11'h001);
    frame("b2b", 15'h0007, 1'b0, 11'h000);
    @(negedge clk);
    check_idle("b2b_end", 15'h0007);

    // reset while bit 6 is on the line
    offer(11'h7FF, 4'd0);
    @(negedge clk);
    drop_valid();
    repeat (6) @(negedge clk);
    chk("mid_ser_before_rst", 32'(bus_l.saida_serial), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_rst", 15'h0000);

    // handshake coincident with reset is discarded
    offer(11'h001, 4'd0);
    @(negedge clk);
    check_idle("rst_hs", 15'h0000);
    drop_valid();
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_release", 15'h0000);

    offer(11'h002, 4'd0);
    frame("d1", 15'h0019, 1'b0, 11'h000);
    @(negedge clk);
    check_idle("d1_end", 15'h0019);

`ifdef HAMMING_INJECAO_ERRO_EN
    offer(11'h000, 4'd5);
    frame("inj", 15'h0010, 1'b0, 11'h000);
    @(negedge clk);
    check_idle("inj_end", 15'h0010);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/codifica_hamming_serial.md
Name: codifica_hamming_serial

Overview:
- Hamming(15,11) transmitter. Accepts an 11-bit data word over a valid/ready handshake and computes the 4 parity bits.
- Registers the 15-bit codeword and shifts it out one bit per clock with a frame-start marker.
- Sits at the transmit end of the link whose receive end deserializes 15 bits and feeds the single-error corrector.
- Codeword bit ordering matches the corrector exactly.

Parameters:
- LSB_PRIMEIRO, 1: 1 = serial order codeword[0]..codeword[14]; 0 = codeword[14]..codeword[0].

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- entrada  input  11  data word to encode
- entrada_valida  input  1  entrada is valid this cycle
- pronto  output  1  block accepts a word this cycle
- palavra  output  15  registered codeword of the frame in flight
- saida_serial  output  1  current serial bit
- saida_valida  output  1  saida_serial holds a frame bit
- saida_inicio  output  1  high on the first bit of each frame only
- ocupado  output  1  frame in progress

Behaviour:
- Codeword index i carries Hamming position i+1.
- Parity bits sit at indices 0, 1, 3, 7.
- Data mapping: d0->2, d1->4, d2->5, d3->6, d4->8, d5->9, d6->10, d7->11, d8->12, d9->13, d10->14.
- Parity equations (even parity):
  - c0 = d0^d1^d3^d4^d6^d8^d10
  - c1 = d0^d2^d3^d5^d6^d9^d10
  - c3 = d1^d2^d3^d7^d8^d9^d10
  - c7 = d4^d5^d6^d7^d8^d9^d10
- Invariant: every emitted codeword has a zero syndrome at the corrector, unless HAMMING_INJECAO_ERRO_EN injects an error.
- FSM states:
  - OCIOSO: pronto=1, ocupado=0, saida_valida=0. On entrada_valida&&pronto: latch the codeword into palavra, clear the bit counter cont (4 bits), go to ENVIANDO.
  - ENVIANDO: saida_valida=1, ocupado=1.
    - saida_serial = palavra[cont] if LSB_PRIMEIRO=1, else palavra[14-cont].
    - saida_inicio = (cont==0).
    - cont increments each cycle.
    - At cont==14 the frame ends.
- Latency: word accepted at edge N; first bit visible in cycle N+1; last bit in cycle N+15.
- Back-to-back handshake:
  - pronto is also high in ENVIANDO when cont==14.
  - A handshake in that cycle loads the new palavra, resets cont to 0 and stays in ENVIANDO, giving continuous frames with no gap.
  - Without a handshake, the FSM returns to OCIOSO and saida_valida drops in the next cycle.
- entrada_valida while pronto=0 is ignored. The source must hold the word; no internal buffering.
- palavra holds its value between frames; it changes only on a handshake.
- Reset (any state, any cycle, including mid-frame):
  - next cycle: state OCIOSO, cont=0, palavra=0, saida_serial=0, saida_valida=0, saida_inicio=0, ocupado=0, pronto=1.
  - A partially sent frame is abandoned, not completed.
  - A handshake coincident with rst is discarded.
- No wrap-around beyond cont==14. cont values 15 are unreachable and must map to OCIOSO if forced.

Optional Feature:
- Macro HAMMING_INJECAO_ERRO_EN.
- Defined: adds input erro_pos[3:0], sampled at handshake.
  - Nonzero k flips codeword index k-1 before it is latched into palavra and serialized.
  - 0 = no flip.
  - Used to exercise the downstream corrector; the corrector must recover the original data word.
- Undefined: port absent; codeword always clean.

Test Plan:
1. Reset, then entrada=11'h000 handshake -> palavra=15'h0000; 15 bits of 0 with saida_inicio only on first; pronto returns high at bit 15.
2. entrada=11'h7FF -> palavra=15'h7FFF; all 15 serial bits 1.
3. entrada=11'h001, LSB_PRIMEIRO=1 -> palavra=15'h0007; serial 1,1,1 then twelve 0s.
4. entrada=11'h400 -> palavra=15'h408B; with LSB_PRIMEIRO=0 the first bit is 1 (index 14).
5. Back-to-back: second word (11'h001) offered at cont==14 of a 11'h400 frame -> saida_valida stays high continuously; saida_inicio pulses again exactly 15 cycles after the first. Separately, assert rst at bit 6 of a frame -> outputs reset next cycle; next frame starts clean.
6. With HAMMING_INJECAO_ERRO_EN: entrada=11'h000, erro_pos=4'd5 -> palavra=15'h0010.
